// File: rtl/qick_fifo_pkg.sv
// Shared types and constants for the dual-clock FIFO read-side drain logic.
package qick_fifo_pkg;

  localparam int unsigned RD_LAT_MAX = 7;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [1:0] {
    SETTLE,
    READY,
    FLUSH
  } rd_state_t;

endpackage

// File: rtl/axis_skid_2.sv
// Two-entry FIFO-ordered valid/ready buffer. The output is always the oldest entry.
module axis_skid_2 #(
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          s_valid_i,
  input  logic [DW-1:0] s_data_i,
  output logic          s_free_o,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o
);

  logic [1:0]    cnt_d, cnt_q;
  logic [DW-1:0] e0_d, e0_q, e1_d, e1_q;
  logic          push, pop;

  assign s_free_o  = (cnt_q != 2'd2);
  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = e0_q;

  always_comb begin
    push  = s_valid_i && s_free_o;
    pop   = m_valid_o && m_ready_i;
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (clr_i) begin
      cnt_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = s_data_i;
          else               e1_d = s_data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        // Simultaneous capture and removal: occupancy unchanged, order kept.
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_d = s_data_i;
          end else begin
            e0_d = e1_q;
            e1_d = s_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

endmodule

// File: rtl/fifo_dc_rd_stream.sv
// Read-side drain stage: issues safe pops from a look-ahead BRAM FIFO and streams words out.
// Optional FIFO_RD_STATS_EN adds handshake (words_o) and stall (stall_o) counters.
module fifo_dc_rd_stream
  import qick_fifo_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          fifo_empty_i,
  input  logic [DW-1:0] fifo_dt_i,
  output logic          fifo_pop_o,
  output logic          fifo_rd_en_o,
  input  logic          flush_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o,
`ifdef FIFO_RD_STATS_EN
  output logic [31:0]   words_o,
  output logic [31:0]   stall_o,
`endif
  output logic          busy_o
);

  localparam logic [CNT_W-1:0] LatCnt    = CNT_W'(RD_LAT);
  // The pop cycle itself is the first settle cycle.
  localparam logic [CNT_W-1:0] LatCntPop = CNT_W'(RD_LAT - 1);

  rd_state_t        state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             seen_d, seen_q;
  logic             rd_en_q;
  logic             capture;
  logic             s_free;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    capture = 1'b0;
    if (flush_i) begin
      state_d = FLUSH;
      seen_d  = 1'b0;
      cnt_d   = LatCnt;
    end else begin
      unique case (state_q)
        SETTLE: begin
          if (cnt_q == '0) state_d = READY;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        READY: begin
          if (!fifo_empty_i && s_free) begin
            capture = 1'b1;
            state_d = SETTLE;
            cnt_d   = LatCntPop;
          end
        end
        FLUSH: begin
          // Wait for the FIFO to report empty, then let its pointers settle.
          if (!seen_q) begin
            if (fifo_empty_i) begin
              seen_d = 1'b1;
              cnt_d  = LatCntPop;
            end
          end else if (cnt_q == '0) begin
            state_d = SETTLE;
            cnt_d   = LatCnt;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = SETTLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= SETTLE;
      cnt_q   <= LatCnt;
      seen_q  <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      rd_en_q <= 1'b1;
    end
  end

  assign fifo_pop_o   = capture;
  assign fifo_rd_en_o = rd_en_q;
  assign busy_o       = (state_q != READY);

  axis_skid_2 #(
    .DW (DW)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (flush_i),
    .s_valid_i (capture),
    .s_data_i  (fifo_dt_i),
    .s_free_o  (s_free),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o)
  );

`ifdef FIFO_RD_STATS_EN
  logic [31:0] words_d, words_q, stall_d, stall_q;

  always_comb begin
    words_d = words_q;
    stall_d = stall_q;
    if (flush_i) begin
      words_d = '0;
      stall_d = '0;
    end else begin
      if (m_valid_o && m_ready_i) words_d = words_q + 32'd1;
      if (state_q == READY && !fifo_empty_i && !s_free && stall_q != '1) begin
        stall_d = stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_d;
      stall_q <= stall_d;
    end
  end

  assign words_o = words_q;
  assign stall_o = stall_q;
`endif

endmodule

// File: tb/tb_fifo_dc_rd_stream.sv
// Self-checking bench for fifo_dc_rd_stream with a queue-based FIFO model and output scoreboard.
module tb_fifo_dc_rd_stream;

  localparam int unsigned DW     = 16;
  localparam int unsigned RD_LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dt = '0;
  logic          flush = 1'b0;
  logic          m_ready = 1'b0;
  logic          pop, rd_en, m_valid, busy;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]   words, stall;
`endif

  int errors = 0;
  int checks = 0;
  int pop_cnt = 0;
  int hs_cnt = 0;
  int valid_cnt = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sb_exp;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always #5 clk = ~clk;

  fifo_dc_rd_stream #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .fifo_empty_i (fifo_empty),
    .fifo_dt_i    (fifo_dt),
    .fifo_pop_o   (pop),
    .fifo_rd_en_o (rd_en),
    .flush_i      (flush),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .m_data_o     (m_data),
`ifdef FIFO_RD_STATS_EN
    .words_o      (words),
    .stall_o      (stall),
`endif
    .busy_o       (busy)
  );

  // FIFO model: pop takes effect at the clock edge.
  always @(posedge clk) begin
    if (rst_n && pop === 1'b1 && fq.size() > 0) void'(fq.pop_front());
  end

  // FIFO outputs refresh and output monitor, both away from the active edge.
  always @(negedge clk) begin
    fifo_empty = (fq.size() == 0);
    fifo_dt    = (fq.size() > 0) ? fq[0] : '0;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (pop === 1'b1) pop_cnt++;
      if (m_valid === 1'b1) valid_cnt++;
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          errors++;
          $display("FAIL hold_stable: valid=%b data=%h required valid=1 data=%h",
                   m_valid, m_data, prev_data);
        end
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: got %h, required no output", m_data);
        end else begin
          sb_exp = exp_q.pop_front();
          if (m_data !== sb_exp) begin
            errors++;
            $display("FAIL scoreboard: got %h, required %h", m_data, sb_exp);
          end
        end
      end
      prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1) && (flush !== 1'b1);
      prev_data  = m_data;
    end
  end

  task automatic hold_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    fq.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic test_reset();
    hold_reset();
    @(negedge clk);
    checks++; if (pop !== 1'b0) begin errors++; $display("FAIL rst_pop: got %b required 0", pop); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b required 0", rd_en); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL rst_data: got %h required 0", m_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b required 1", busy); end
  endtask

  task automatic test_first_pop();
    int p1, p2;
    p1 = RD_LAT + 1;
    p2 = 2 * (RD_LAT + 1);
    m_ready = 1'b1;
    hold_reset();
    load(16'h00A1);
    load(16'h00B2);
    release_reset();
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      checks++;
      if (pop !== (n == p1 || n == p2)) begin
        errors++; $display("FAIL first_pop: cycle %0d pop=%b required %b", n, pop, (n == p1 || n == p2));
      end
      checks++;
      if (m_valid !== (n == p1 + 1 || n == p2 + 1)) begin
        errors++; $display("FAIL first_valid: cycle %0d valid=%b required %b", n, m_valid,
                           (n == p1 + 1 || n == p2 + 1));
      end
      if (n == 1) begin
        checks++;
        if (rd_en !== 1'b1) begin errors++; $display("FAIL rd_en: got %b required 1", rd_en); end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL first_drain: %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int p0, h0;
    bit done;
    m_ready = 1'b0;
    hold_reset();
    for (int i = 0; i < 5; i++) load(16'h0010 + 16'(i));
    release_reset();
    p0 = pop_cnt;
    h0 = hs_cnt;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (pop_cnt - p0 != 2) begin errors++; $display("FAIL bp_pops: got %0d required 2", pop_cnt - p0); end
    checks++; if (fq.size() != 3) begin errors++; $display("FAIL bp_fifo_left: got %0d required 3", fq.size()); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b required 1", m_valid); end
    m_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0);
    end
    checks++; if (!done) begin errors++; $display("FAIL bp_drain: %0d left required 0", exp_q.size()); end
    checks++; if (hs_cnt - h0 != 5) begin errors++; $display("FAIL bp_count: got %0d required 5", hs_cnt - h0); end
  endtask

  task automatic test_empty();
    int p0, v0;
    m_ready = 1'b1;
    hold_reset();
    release_reset();
    p0 = pop_cnt;
    v0 = valid_cnt;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (pop_cnt != p0) begin errors++; $display("FAIL empty_pop: got %0d pops required 0", pop_cnt - p0); end
    checks++; if (valid_cnt != v0) begin errors++; $display("FAIL empty_valid: got %0d required 0", valid_cnt - v0); end
  endtask

  task automatic test_same_cycle();
    bit done;
    m_ready = 1'b0;
    hold_reset();
    load(16'h003A);
    release_reset();
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      done = (pop === 1'b1);
      @(posedge clk);
      #1;
    end
    checks++; if (!done) begin errors++; $display("FAIL sc_pop1: got no pop required pop"); end
    load(16'h004B);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (pop === 1'b1) begin
        done = 1'b1;
        m_ready = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL sc_pop2: got no pop required pop"); end
    @(posedge clk);
    #1 m_ready = 1'b0;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL sc_valid: got %b required 1", m_valid); end
    checks++; if (m_data !== 16'h004B) begin errors++; $display("FAIL sc_data: got %h required 004b", m_data); end
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL sc_occupancy: valid=%b required 0", m_valid); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sc_drain: %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    int p0;
    bit done;
    m_ready = 1'b0;
    hold_reset();
    load(16'h0011);
    load(16'h0022);
    load(16'h0033);
    release_reset();
    p0 = pop_cnt;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (pop_cnt - p0 >= 2);
    end
    checks++; if (!done) begin errors++; $display("FAIL fl_fill: got %0d pops required 2", pop_cnt - p0); end
    // FIFO still shows a stale word while it is flushing.
    fq.delete();
    fq.push_back(16'h00EE);
    exp_q.delete();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b required 0", m_valid); end
    p0 = pop_cnt;
    repeat (4) @(posedge clk);
    #1;
    fq.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL fl_busy: wait cycle %0d busy=%b required 1", k, busy); end
      @(posedge clk);
      #1;
      if (k == 1) load(16'h005C);
    end
    checks++; if (pop_cnt != p0) begin errors++; $display("FAIL fl_no_pop: got %0d pops required 0", pop_cnt - p0); end
    m_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0);
    end
    checks++; if (!done) begin errors++; $display("FAIL fl_refill: %0d left required 0", exp_q.size()); end
    checks++; if (pop_cnt - p0 != 1) begin errors++; $display("FAIL fl_pops: got %0d required 1", pop_cnt - p0); end
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    int p0;
    bit done;
    m_ready = 1'b1;
    hold_reset();
    for (int i = 0; i < 10; i++) load(16'h0100 + 16'(i));
    release_reset();
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0);
    end
    @(posedge clk);
    #1;
    checks++; if (!done) begin errors++; $display("FAIL st_drain: %0d left required 0", exp_q.size()); end
    checks++; if (words !== 32'd10) begin errors++; $display("FAIL st_words: got %0d required 10", words); end
    m_ready = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 3; i++) load(16'h0200 + 16'(i));
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (pop_cnt - p0 >= 2) && (busy === 1'b0);
    end
    checks++; if (!done) begin errors++; $display("FAIL st_full: buffer never full in READY"); end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 m_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0);
    end
    checks++; if (stall !== 32'd3) begin errors++; $display("FAIL st_stall: got %0d required 3", stall); end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checks++; if (words !== 32'd0) begin errors++; $display("FAIL st_words_clr: got %0d required 0", words); end
    checks++; if (stall !== 32'd0) begin errors++; $display("FAIL st_stall_clr: got %0d required 0", stall); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_pop();
    test_backpressure();
    test_empty();
    test_same_cycle();
    test_flush();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
